// File: rtl/core_pkg.sv
// Shared fetch-stage types and constants for the RV32I core.
// Optional feature macro used by instr_fetch: IF_MISALIGN_CHK_EN.
package core_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    ERR
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {pc, instr} pairs between IM fetch and decode.
// Head outputs come straight from the storage registers; flush empties in one cycle.
module fetch_queue
  import core_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  logic [PC_W-1:0]    push_pc_i,
  input  logic [INSTR_W-1:0] push_instr_i,
  output logic [CNT_W-1:0]   count_o,
  output logic               head_valid_o,
  output logic [PC_W-1:0]    head_pc_o,
  output logic [INSTR_W-1:0] head_instr_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q;
  logic [PTR_W-1:0] rd_q;
  logic [CNT_W-1:0] cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= '{pc: push_pc_i, instr: push_instr_i};
        wr_q        <= wr_q + PTR_W'(1);
      end
      if (pop_i) rd_q <= rd_q + PTR_W'(1);
      if (push_i && !pop_i)      cnt_q <= cnt_q + CNT_W'(1);
      else if (!push_i && pop_i) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign count_o      = cnt_q;
  assign head_valid_o = (cnt_q != '0);
  assign head_pc_o    = mem_q[rd_q].pc;
  assign head_instr_o = mem_q[rd_q].instr;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register, fetch FSM, redirect handling and prefetch queue toward decode.
// Define IF_MISALIGN_CHK_EN to trap misaligned redirects into a sticky ERR state.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_instr,
  input  logic              redir_valid,
  input  logic [31:0]       redir_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [31:0]       out_pc,
  output logic              misalign_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t     state_q;
  logic [PC_W-1:0]  pc_q;
  logic             misalign_err_q;
  logic [CNT_W-1:0] count;
  logic             pop;
  logic             push;
  logic             redir_ok;
  logic             redir_bad;
  logic             flush;
  logic [PC_W-1:0]  redir_tgt;

`ifdef IF_MISALIGN_CHK_EN
  assign redir_bad = redir_valid && (state_q != ERR) && (redir_pc[1:0] != 2'b00);
`else
  logic unused_redir_lsb;
  assign unused_redir_lsb = ^redir_pc[1:0];
  assign redir_bad        = 1'b0;
`endif

  assign redir_tgt = {redir_pc[31:2], 2'b00};
  assign redir_ok  = redir_valid && (state_q != ERR) && !redir_bad;
  assign flush     = redir_ok || redir_bad;
  assign pop       = out_valid && out_ready;
  // A pop in the same cycle frees the slot a full queue needs for the new word.
  assign push      = (state_q == RUN) && !redir_valid && ((count < CNT_W'(DEPTH)) || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      pc_q           <= RESET_PC;
      misalign_err_q <= 1'b0;
    end else if (redir_bad) begin
      state_q        <= ERR;
      misalign_err_q <= 1'b1;
    end else if (state_q != ERR) begin
      if (redir_ok)  pc_q <= redir_tgt;
      else if (push) pc_q <= pc_q + 32'd4;
      state_q <= fetch_en ? RUN : IDLE;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (pop),
    .flush_i      (flush),
    .push_pc_i    (pc_q),
    .push_instr_i (im_instr),
    .count_o      (count),
    .head_valid_o (out_valid),
    .head_pc_o    (out_pc),
    .head_instr_o (out_instr)
  );

  assign im_addr      = pc_q[ADDR_W+1:2];
  assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: per-cycle vector tables plus a scoreboard of expected
// decode-side words for redirect, stall, drain and async-reset sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic [15:0] im_addr;
  logic [31:0] im_instr;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        misalign_err;

  always #5 clk = ~clk;

  // IM model: word[i] = 0x0010_0000 | i
  assign im_instr = 32'h0010_0000 | {16'h0000, im_addr};

  instr_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .im_addr      (im_addr),
    .im_instr     (im_instr),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .misalign_err (misalign_err)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic        fen;
    logic        rdy;
    logic [15:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  bit   sb_en = 1'b0;
  exp_t sb[$];
  vec_t tab[16];

  function automatic logic [31:0] im_word(input logic [31:0] pc);
    return 32'h0010_0000 | {16'h0000, pc[17:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sb_push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.pc    = start + 32'(4 * i);
      e.instr = im_word(e.pc);
      sb.push_back(e);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; a handshake seen now completes at the next rise.
  task automatic cycle(input logic fen, input logic rdy, input logic rv, input logic [31:0] rpc);
    fetch_en    = fen;
    out_ready   = rdy;
    redir_valid = rv;
    redir_pc    = rpc;
    if (sb_en && out_valid && rdy) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h, nothing expected", out_pc);
      end else begin
        e = sb.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_instr", out_instr, e.instr);
      end
      n_pop++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    fetch_en    = 1'b0;
    out_ready   = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_instr", out_instr, 32'h0);
    check("rst_err", 32'(misalign_err), 32'h0);
    check("rst_addr", 32'(im_addr), 32'h0);
    rst = 1'b0;
    sb.delete();
    n_pop = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [15:0] a1;

    // Free-running fetch, then decode stalled for the first 5 cycles.
    tab[0]  = '{1'b1, 1'b1, 16'd0, 1'b0, 32'h00};
    tab[1]  = '{1'b1, 1'b1, 16'd0, 1'b0, 32'h00};
    tab[2]  = '{1'b1, 1'b1, 16'd1, 1'b1, 32'h00};
    tab[3]  = '{1'b1, 1'b1, 16'd2, 1'b1, 32'h04};
    tab[4]  = '{1'b1, 1'b1, 16'd3, 1'b1, 32'h08};
    tab[5]  = '{1'b1, 1'b1, 16'd4, 1'b1, 32'h0C};
    tab[6]  = '{1'b1, 1'b1, 16'd5, 1'b1, 32'h10};
    tab[7]  = '{1'b1, 1'b1, 16'd6, 1'b1, 32'h14};
    tab[8]  = '{1'b1, 1'b0, 16'd0, 1'b0, 32'h00};
    tab[9]  = '{1'b1, 1'b0, 16'd0, 1'b0, 32'h00};
    tab[10] = '{1'b1, 1'b0, 16'd1, 1'b1, 32'h00};
    tab[11] = '{1'b1, 1'b0, 16'd2, 1'b1, 32'h00};
    tab[12] = '{1'b1, 1'b0, 16'd2, 1'b1, 32'h00};
    tab[13] = '{1'b1, 1'b1, 16'd2, 1'b1, 32'h00};
    tab[14] = '{1'b1, 1'b1, 16'd3, 1'b1, 32'h04};
    tab[15] = '{1'b1, 1'b1, 16'd4, 1'b1, 32'h08};

    for (int i = 0; i < 16; i++) begin
      if (i == 0 || i == 8) do_reset();
      fetch_en    = tab[i].fen;
      out_ready   = tab[i].rdy;
      redir_valid = 1'b0;
      redir_pc    = 32'h0;
      check($sformatf("tab%0d_addr", i), 32'(im_addr), 32'(tab[i].addr));
      check($sformatf("tab%0d_valid", i), 32'(out_valid), 32'(tab[i].vld));
      if (tab[i].vld) begin
        check($sformatf("tab%0d_pc", i), out_pc, tab[i].pc);
        check($sformatf("tab%0d_instr", i), out_instr, im_word(tab[i].pc));
      end
      @(negedge clk);
    end

    // Redirect to 0x40 while the queue is full; head 0 pops in the redirect cycle.
    do_reset();
    sb_en = 1'b1;
    sb_push_seq(32'h0, 3);
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("c_full_valid", 32'(out_valid), 32'h1);
    check("c_full_addr", 32'(im_addr), 32'h2);
    cycle(1'b1, 1'b1, 1'b1, 32'h40);
    sb.delete();
    sb_push_seq(32'h40, 32);
    n_pop = 0;
    check("c_bubble_valid", 32'(out_valid), 32'h0);
    check("c_redir_addr", 32'(im_addr), 32'h10);
    cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("c_target_valid", 32'(out_valid), 32'h1);
    check("c_target_pc", out_pc, 32'h40);
    check("c_target_instr", out_instr, 32'h0010_0010);
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("c_pops", 32'(n_pop), 32'd5);

    // fetch_en low for 3 cycles: queue drains, PC frozen, stream resumes without a gap.
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    a1 = im_addr;
    check("d_frozen_addr_val", 32'(a1), 32'h17);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("d_frozen_addr1", 32'(im_addr), 32'(a1));
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("d_frozen_addr2", 32'(im_addr), 32'(a1));
    check("d_drained", 32'(out_valid), 32'h0);
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("d_pops", 32'(n_pop), 32'd11);

    // Misaligned redirect target 0x42.
    cycle(1'b1, 1'b1, 1'b1, 32'h42);
    sb.delete();
`ifdef IF_MISALIGN_CHK_EN
    for (int i = 0; i < 5; i++) begin
      check("e_err_flag", 32'(misalign_err), 32'h1);
      check("e_err_valid", 32'(out_valid), 32'h0);
      cycle(1'b1, 1'b1, 1'b0, 32'h0);
    end
`else
    sb_push_seq(32'h40, 8);
    n_pop = 0;
    check("e_no_err", 32'(misalign_err), 32'h0);
    check("e_bubble", 32'(out_valid), 32'h0);
    check("e_addr", 32'(im_addr), 32'h10);
    repeat (4) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("e_pops", 32'(n_pop), 32'd3);
    // Redirect while fetch_en is low: PC moves, nothing is fetched.
    cycle(1'b0, 1'b1, 1'b1, 32'h80);
    sb.delete();
    check("g_idle_redir_addr", 32'(im_addr), 32'h20);
    check("g_idle_redir_valid", 32'(out_valid), 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h0);
    check("g_idle_hold_addr", 32'(im_addr), 32'h20);
    check("g_idle_hold_valid", 32'(out_valid), 32'h0);
`endif

    // Asynchronous reset between edges with a full queue.
    do_reset();
    sb_en = 1'b1;
    repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
    check("f_full_valid", 32'(out_valid), 32'h1);
    check("f_full_addr", 32'(im_addr), 32'h2);
    #2;
    rst = 1'b1;
    #1;
    check("f_async_valid", 32'(out_valid), 32'h0);
    check("f_async_addr", 32'(im_addr), 32'h0);
    check("f_async_instr", out_instr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    sb_push_seq(32'h0, 8);
    n_pop = 0;
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
    check("f_pops", 32'(n_pop), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
